id_stage: RTL and testbench

Registered RV32I decode stage that produces the 4-bit ALU operation code and operand-select controls consumed by the ALU in EX. It sits between fetch and execute. It accepts one instruction per cycle over a valid/ready handshake and holds one decoded entry in a pipeline register. It supports flush (branch redirect) and reports illegal instructions.

---
 rtl/rv_pkg.sv | 69 ++++++
 rtl/id_stage_if.sv | 40 ++++
 rtl/rv_decoder.sv | 120 ++++++++++++
 rtl/id_stage.sv | 63 ++++++
 tb/tb_id_stage.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_pkg.sv
// Shared RV32I decode types: ALU operation codes, opcodes, instruction classes
// and the decoded-entry record carried from ID to EX.
package rv_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_AND  = 4'b0100,
    ALU_OR   = 4'b0101,
    ALU_XOR  = 4'b0110,
    ALU_SLL  = 4'b0111,
    ALU_SRL  = 4'b1000,
    ALU_SRA  = 4'b1001
  } alu_op_t;

  typedef enum logic [1:0] {
    CLS_ALU    = 2'd0,
    CLS_LOAD   = 2'd1,
    CLS_STORE  = 2'd2,
    CLS_BRANCH = 2'd3
  } instr_class_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    alu_op_t      alu_op;
    logic [4:0]   rs1;
    logic [4:0]   rs2;
    logic [4:0]   rd;
    logic         rd_we;
    logic [31:0]  imm;
    logic [31:0]  pc;
    logic         op1_pc;
    logic         op2_imm;
    instr_class_t cls;
    logic [2:0]   funct3;
    logic         illegal;
  } decoded_t;

  // Register/immediate arithmetic mapping; alt selects SUB/SRA on the shared funct3 slots.
  function automatic alu_op_t alu_from_funct3(input logic [2:0] f3, input logic alt);
    alu_op_t op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// Fetch-to-ID and ID-to-EX handshake bundle. The master side drives the
// instruction beat and consumes the decoded entry; the slave side is the stage.
interface id_stage_if #(
  parameter int unsigned XLEN = rv_pkg::XLEN
);
  import rv_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_instr;
  logic [XLEN-1:0] in_pc;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [3:0]      out_alu_op;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [4:0]      out_rd;
  logic            out_rd_we;
  logic [XLEN-1:0] out_imm;
  logic [XLEN-1:0] out_pc;
  logic            out_op1_pc;
  logic            out_op2_imm;
  logic [1:0]      out_class;
  logic [2:0]      out_funct3;
  logic            out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_alu_op, out_rs1, out_rs2, out_rd, out_rd_we,
           out_imm, out_pc, out_op1_pc, out_op2_imm, out_class, out_funct3, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, out_alu_op, out_rs1, out_rs2, out_rd, out_rd_we,
           out_imm, out_pc, out_op1_pc, out_op2_imm, out_class, out_funct3, out_illegal
  );

endinterface

// File: rtl/rv_decoder.sv
// Combinational RV32I decoder: instruction word to ALU control record.
// The pc field is left zero; the pipeline register fills it in.
module rv_decoder
  import rv_pkg::*;
(
  input  logic [31:0] instr,
  output decoded_t    dec
);

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] shamt;
  logic        ill;
  logic        writes;

  assign opc   = instr[6:0];
  assign f3    = instr[14:12];
  assign f7    = instr[31:25];
  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign shamt = {27'b0, instr[24:20]};

  always_comb begin
    dec        = '0;
    dec.rs1    = instr[19:15];
    dec.rs2    = instr[24:20];
    dec.rd     = instr[11:7];
    dec.funct3 = f3;
    dec.alu_op = ALU_ADD;
    dec.cls    = CLS_ALU;
    ill        = 1'b0;
    writes     = 1'b0;

    case (opc)
      OPC_OP: begin
        writes     = 1'b1;
        dec.alu_op = alu_from_funct3(f3, f7 == F7_ALT);
        ill        = !((f7 == F7_BASE) ||
                       ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101))));
      end
      OPC_OP_IMM: begin
        writes      = 1'b1;
        dec.op2_imm = 1'b1;
        case (f3)
          3'b001: begin
            dec.alu_op = ALU_SLL;
            dec.imm    = shamt;
            ill        = (f7 != F7_BASE);
          end
          3'b101: begin
            dec.alu_op = alu_from_funct3(f3, f7 == F7_ALT);
            dec.imm    = shamt;
            ill        = !((f7 == F7_BASE) || (f7 == F7_ALT));
          end
          default: begin
            // funct7 bits are immediate here, so funct3 000 is always ADDI.
            dec.alu_op = alu_from_funct3(f3, 1'b0);
            dec.imm    = imm_i;
          end
        endcase
      end
      OPC_LUI: begin
        writes      = 1'b1;
        dec.rs1     = '0;
        dec.op2_imm = 1'b1;
        dec.imm     = imm_u;
      end
      OPC_AUIPC: begin
        writes      = 1'b1;
        dec.op1_pc  = 1'b1;
        dec.op2_imm = 1'b1;
        dec.imm     = imm_u;
      end
      OPC_LOAD: begin
        writes      = 1'b1;
        dec.cls     = CLS_LOAD;
        dec.op2_imm = 1'b1;
        dec.imm     = imm_i;
        ill         = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OPC_STORE: begin
        dec.cls     = CLS_STORE;
        dec.op2_imm = 1'b1;
        dec.imm     = imm_s;
        ill         = (f3 > 3'b010);
      end
      OPC_BRANCH: begin
        dec.cls = CLS_BRANCH;
        dec.imm = imm_b;
        case (f3)
          3'b000, 3'b001: dec.alu_op = ALU_SUB;
          3'b100, 3'b101: dec.alu_op = ALU_SLT;
          3'b110, 3'b111: dec.alu_op = ALU_SLTU;
          default:        ill        = 1'b1;
        endcase
      end
      default: ill = 1'b1;
    endcase

    dec.rd_we = writes && !ill && (dec.rd != 5'd0);

    // Illegal entries still travel to EX, so they are reduced to a harmless ADD.
    if (ill) begin
      dec.alu_op  = ALU_ADD;
      dec.cls     = CLS_ALU;
      dec.imm     = '0;
      dec.op1_pc  = 1'b0;
      dec.op2_imm = 1'b0;
    end
    dec.illegal = ill;
  end

endmodule

// File: rtl/id_stage.sv
// Registered decode stage: one-entry pipeline register behind a valid/ready
// handshake, with flush for branch redirects.
module id_stage
  import rv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input logic      clk,
  input logic      rst_n,
  id_stage_if.slave bus
);

  decoded_t        dec;
  decoded_t        nxt;
  decoded_t        q;
  logic            valid_q;
  logic            accept;
  logic [XLEN-1:0] pc_in;

  rv_decoder u_dec (
    .instr (bus.in_instr),
    .dec   (dec)
  );

  assign pc_in        = bus.in_pc;
  assign bus.in_ready = !valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    nxt    = dec;
    nxt.pc = pc_in;
  end

  // Flush beats accept: a beat arriving alongside a redirect is on the wrong path.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      q       <= '0;
    end else if (bus.flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      q       <= nxt;
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.out_valid   = valid_q;
  assign bus.out_alu_op  = q.alu_op;
  assign bus.out_rs1     = q.rs1;
  assign bus.out_rs2     = q.rs2;
  assign bus.out_rd      = q.rd;
  assign bus.out_rd_we   = q.rd_we;
  assign bus.out_imm     = q.imm;
  assign bus.out_pc      = q.pc;
  assign bus.out_op1_pc  = q.op1_pc;
  assign bus.out_op2_imm = q.op2_imm;
  assign bus.out_class   = q.cls;
  assign bus.out_funct3  = q.funct3;
  assign bus.out_illegal = q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: instruction-level reference model plus per-cycle compare,
// with directed vectors and hand-computed literal checks.
module tb_id_stage;

  typedef struct packed {
    logic [3:0]  alu;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rd_we;
    logic [31:0] imm;
    logic [31:0] pc;
    logic        op1_pc;
    logic        op2_imm;
    logic [1:0]  cls;
    logic [2:0]  f3;
    logic        ill;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  id_stage_if #(.XLEN(32)) bus ();

  id_stage #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   total = 0;
  int   bad = 0;
  logic cmp_en = 1'b0;
  int   cons [logic [31:0]];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference decode straight from the RV32I instruction tables.
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
    exp_t e;
    logic [3:0] tab [8];
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic ok;
    logic wr;
    tab = '{4'd0, 4'd7, 4'd2, 4'd3, 4'd6, 4'd8, 4'd5, 4'd4};
    op = ins[6:0];
    f3 = ins[14:12];
    f7 = ins[31:25];
    e = '0;
    e.rs1 = ins[19:15];
    e.rs2 = ins[24:20];
    e.rd  = ins[11:7];
    e.f3  = f3;
    e.pc  = pc;
    ok = 1'b1;
    wr = 1'b0;
    case (op)
      7'h33: begin
        wr = 1'b1;
        e.alu = tab[f3];
        if (f7 == 7'h20 && f3 == 3'd0) e.alu = 4'd1;
        if (f7 == 7'h20 && f3 == 3'd5) e.alu = 4'd9;
        ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      end
      7'h13: begin
        wr = 1'b1;
        e.op2_imm = 1'b1;
        e.alu = tab[f3];
        e.imm = {{20{ins[31]}}, ins[31:20]};
        if (f3 == 3'd1) begin
          ok = (f7 == 7'h00);
          e.imm = {27'b0, ins[24:20]};
        end
        if (f3 == 3'd5) begin
          ok = (f7 == 7'h00) || (f7 == 7'h20);
          e.imm = {27'b0, ins[24:20]};
          if (f7 == 7'h20) e.alu = 4'd9;
        end
      end
      7'h37: begin
        wr = 1'b1; e.rs1 = 5'd0; e.op2_imm = 1'b1; e.imm = ins & 32'hFFFFF000;
      end
      7'h17: begin
        wr = 1'b1; e.op1_pc = 1'b1; e.op2_imm = 1'b1; e.imm = ins & 32'hFFFFF000;
      end
      7'h03: begin
        wr = 1'b1; e.cls = 2'd1; e.op2_imm = 1'b1;
        e.imm = {{20{ins[31]}}, ins[31:20]};
        ok = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      end
      7'h23: begin
        e.cls = 2'd2; e.op2_imm = 1'b1;
        e.imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        ok = (f3 <= 3'd2);
      end
      7'h63: begin
        e.cls = 2'd3;
        e.imm = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
        e.alu = (f3 < 3'd2) ? 4'd1 : (f3 < 3'd6) ? 4'd2 : 4'd3;
        ok = !(f3 == 3'd2 || f3 == 3'd3);
      end
      default: ok = 1'b0;
    endcase
    e.rd_we = wr && ok && (e.rd != 5'd0);
    if (!ok) begin
      e.alu = 4'd0; e.cls = 2'd0; e.imm = 32'd0;
      e.op1_pc = 1'b0; e.op2_imm = 1'b0; e.ill = 1'b1;
    end
    return e;
  endfunction

  // Stage-level expectation: one held entry, updated by the handshake rules.
  exp_t m;
  logic m_valid = 1'b0;
  logic m_known = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_valid = 1'b0;
      m = '0;
      m_known = 1'b1;
    end else if (bus.flush) begin
      m_valid = 1'b0;
    end else if (bus.in_valid && (!m_valid || bus.out_ready)) begin
      m_valid = 1'b1;
      m = model(bus.in_instr, bus.in_pc);
      m_known = 1'b1;
    end else if (bus.out_ready) begin
      m_valid = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("in_ready", bus.in_ready, !m_valid || bus.out_ready);
      chk("out_valid", bus.out_valid, m_valid);
      if (m_valid || (m_known && !m_valid && m == '0)) begin
        chk("alu_op", bus.out_alu_op, m.alu);
        chk("rs1", bus.out_rs1, m.rs1);
        chk("rs2", bus.out_rs2, m.rs2);
        chk("rd", bus.out_rd, m.rd);
        chk("rd_we", bus.out_rd_we, m.rd_we);
        chk("imm", bus.out_imm, m.imm);
        chk("pc", bus.out_pc, m.pc);
        chk("op1_pc", bus.out_op1_pc, m.op1_pc);
        chk("op2_imm", bus.out_op2_imm, m.op2_imm);
        chk("class", bus.out_class, m.cls);
        chk("funct3", bus.out_funct3, m.f3);
        chk("illegal", bus.out_illegal, m.ill);
      end
      if (rst_n && bus.out_valid && bus.out_ready) begin
        if (cons.exists(bus.out_pc)) cons[bus.out_pc] = cons[bus.out_pc] + 1;
        else cons[bus.out_pc] = 1;
      end
    end
  end

  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic rdy, input logic fl);
    bus.in_valid  = v;
    bus.in_instr  = ins;
    bus.in_pc     = pc;
    bus.out_ready = rdy;
    bus.flush     = fl;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] sweep [16];
  exp_t        pin;

  initial begin
    bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0;
    bus.out_ready = 1'b0; bus.flush = 1'b0;
    sweep = '{32'h00001397, 32'hFFC0A283, 32'h0020A423, 32'h01F09093,
              32'h41F09093, 32'hFFF00093, 32'h00208033, 32'h00002063,
              32'h00003003, 32'h00003023, 32'h0000006F, 32'h003130B3,
              32'h0FF14093, 32'h0020E1B3, 32'h0020A1B3, 32'h00515093};

    // Pin the reference model against hand-decoded words.
    pin = model(32'hFE20ECE3, 32'h0);
    chk("pin_bltu_imm", pin.imm, 32'hFFFFFFF8);
    chk("pin_bltu_alu", pin.alu, 4'b0011);
    pin = model(32'h0020A423, 32'h0);
    chk("pin_sw_imm", pin.imm, 32'h00000008);
    pin = model(32'h12345237, 32'h0);
    chk("pin_lui_imm", pin.imm, 32'h12345000);

    @(posedge clk); #1;
    cmp_en = 1'b1;
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("rst_valid", bus.out_valid, 1'b0);
    chk("rst_ready", bus.in_ready, 1'b1);
    rst_n = 1'b1;

    step(1'b1, 32'h002081B3, 32'h100, 1'b1, 1'b0);
    chk("add_valid", bus.out_valid, 1'b1);
    chk("add_alu", bus.out_alu_op, 4'b0000);
    chk("add_rs1", bus.out_rs1, 5'd1);
    chk("add_rs2", bus.out_rs2, 5'd2);
    chk("add_rd", bus.out_rd, 5'd3);
    chk("add_we", bus.out_rd_we, 1'b1);
    chk("add_op2", bus.out_op2_imm, 1'b0);

    step(1'b1, 32'h407302B3, 32'h104, 1'b1, 1'b0);
    chk("sub_alu", bus.out_alu_op, 4'b0001);
    step(1'b1, 32'h40315093, 32'h108, 1'b1, 1'b0);
    chk("srai_alu", bus.out_alu_op, 4'b1001);
    chk("srai_op2", bus.out_op2_imm, 1'b1);
    chk("srai_imm", bus.out_imm, 32'h00000003);

    step(1'b1, 32'hFE20ECE3, 32'h10C, 1'b1, 1'b0);
    chk("bltu_class", bus.out_class, 2'd3);
    chk("bltu_alu", bus.out_alu_op, 4'b0011);
    chk("bltu_imm", bus.out_imm, 32'hFFFFFFF8);
    chk("bltu_op2", bus.out_op2_imm, 1'b0);
    chk("bltu_we", bus.out_rd_we, 1'b0);

    step(1'b1, 32'h12345237, 32'h110, 1'b1, 1'b0);
    chk("lui_imm", bus.out_imm, 32'h12345000);
    chk("lui_rs1", bus.out_rs1, 5'd0);
    chk("lui_op2", bus.out_op2_imm, 1'b1);

    // Backpressure: entry A held three cycles while B waits.
    step(1'b1, 32'h00500093, 32'h200, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'h00A00113, 32'h204, 1'b0, 1'b0);
      chk("bp_ready", bus.in_ready, 1'b0);
      chk("bp_pc", bus.out_pc, 32'h200);
      chk("bp_imm", bus.out_imm, 32'h5);
    end
    step(1'b1, 32'h00A00113, 32'h204, 1'b1, 1'b0);
    chk("bp_next_pc", bus.out_pc, 32'h204);
    chk("bp_next_imm", bus.out_imm, 32'hA);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("bp_drain", bus.out_valid, 1'b0);

    // Flush with a beat accepted the same cycle.
    step(1'b1, 32'h00700193, 32'h300, 1'b1, 1'b0);
    step(1'b1, 32'h00800213, 32'h304, 1'b1, 1'b1);
    chk("flush_valid", bus.out_valid, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("flush_gone", bus.out_valid, 1'b0);

    // Reset while an entry is held.
    step(1'b1, 32'hFFF00093, 32'h400, 1'b0, 1'b0);
    rst_n = 1'b0;
    step(1'b1, 32'h002081B3, 32'h404, 1'b1, 1'b0);
    chk("rst2_valid", bus.out_valid, 1'b0);
    chk("rst2_pc", bus.out_pc, 32'h0);
    chk("rst2_imm", bus.out_imm, 32'h0);
    chk("rst2_rd", bus.out_rd, 5'd0);
    chk("rst2_funct3", bus.out_funct3, 3'd0);
    rst_n = 1'b1;

    step(1'b1, 32'h00000000, 32'h500, 1'b1, 1'b0);
    chk("ill0_flag", bus.out_illegal, 1'b1);
    chk("ill0_we", bus.out_rd_we, 1'b0);
    chk("ill0_alu", bus.out_alu_op, 4'b0000);
    chk("ill0_valid", bus.out_valid, 1'b1);
    step(1'b1, 32'h4020F1B3, 32'h504, 1'b1, 1'b0);
    chk("illand_flag", bus.out_illegal, 1'b1);
    chk("illand_we", bus.out_rd_we, 1'b0);
    chk("illand_alu", bus.out_alu_op, 4'b0000);
    chk("illand_valid", bus.out_valid, 1'b1);
    step(1'b1, 32'h0020F1B3, 32'h508, 1'b1, 1'b0);
    chk("and_alu", bus.out_alu_op, 4'b0100);
    chk("and_flag", bus.out_illegal, 1'b0);

    // Mixed-readiness sweep; each beat is re-offered until it is taken.
    for (int i = 0; i < 16; i++) begin
      logic taken;
      taken = 1'b0;
      for (int t = 0; t < 4 && !taken; t++) begin
        bus.in_valid = 1'b1; bus.in_instr = sweep[i];
        bus.in_pc = 32'h600 + 32'(i * 4);
        bus.out_ready = (t > 0) || ((i % 3) != 2);
        bus.flush = 1'b0;
        #1;
        taken = bus.in_ready;
        @(posedge clk); #1;
      end
      if (!taken) chk("sweep_take", 32'(taken), 32'd1);
    end
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    chk("cons_a", cons.exists(32'h200) ? cons[32'h200] : 0, 32'd1);
    chk("cons_b", cons.exists(32'h204) ? cons[32'h204] : 0, 32'd1);
    chk("cons_flushed", 32'(cons.exists(32'h304)), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
